// File: rtl/ecc_pkg.sv
// Shared types and lookup helpers for the Hamming SEC-DED engine.
package ecc_pkg;

  localparam int CW = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENC,
    S_NOISE,
    S_DEC,
    S_CORR,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_ENCODE       = 2'd0;
  localparam logic [1:0] OP_DECODE       = 2'd1;
  localparam logic [1:0] OP_FULL_CHANNEL = 2'd2;

  localparam logic [1:0] WC_8  = 2'd0;
  localparam logic [1:0] WC_16 = 2'd1;
  localparam logic [1:0] WC_32 = 2'd2;

  function automatic int unsigned n_of(input logic [1:0] wc);
    case (wc)
      WC_8:    return 8;
      WC_16:   return 16;
      WC_32:   return 32;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned k_of(input logic [1:0] wc);
    case (wc)
      WC_8:    return 4;
      WC_16:   return 11;
      WC_32:   return 26;
      default: return 0;
    endcase
  endfunction

  function automatic logic [CW-1:0] n_mask(input logic [1:0] wc);
    case (wc)
      WC_8:    return 32'h0000_00FF;
      WC_16:   return 32'h0000_FFFF;
      WC_32:   return 32'hFFFF_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Info positions skip 1,2,4,8,16; the sequence is the same for every N, only K truncates it.
  function automatic logic [4:0] info_pos(input int unsigned k);
    if (k == 0)       return 5'd3;
    else if (k < 4)   return 5'(k + 4);
    else if (k < 11)  return 5'(k + 5);
    else              return 5'(k + 6);
  endfunction

endpackage

// File: rtl/ecc_parity_gen.sv
// Syndrome (XOR of set-bit indices) and overall parity of a word masked to N bits.
module ecc_parity_gen
  import ecc_pkg::*;
(
  input  logic [CW-1:0] i_word,
  input  logic [1:0]    i_wc,
  output logic [4:0]    o_syn,
  output logic          o_par
);

  logic [CW-1:0] w_word;

  assign w_word = i_word & n_mask(i_wc);

  always_comb begin
    o_syn = '0;
    for (int i = 1; i < CW; i++) begin
      if (w_word[i]) o_syn = o_syn ^ 5'(i);
    end
  end

  assign o_par = ^w_word;

endmodule

// File: rtl/ecc_engine.sv
// Sequential SEC-DED encode / decode / full-channel engine for 8/16/32-bit codewords.
// state   | meaning
// S_IDLE  | wait for start, capture operands
// S_ENC   | build codeword from info bits
// S_NOISE | XOR noise mask onto codeword
// S_DEC   | latch syndrome and overall parity
// S_CORR  | correct, extract info, publish result
// S_DONE  | done pulse cycle, then back to idle
module ecc_engine
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AMBA_WORD-1:0]  CTRL,
  input  logic [AMBA_WORD-1:0]  DATA_IN,
  input  logic [AMBA_WORD-1:0]  CODEWORD_WIDTH,
  input  logic [AMBA_WORD-1:0]  NOISE,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  operation_done,
  output logic [1:0]            num_of_errors
);

  state_t                r_state;
  logic [1:0]            r_op;
  logic [1:0]            r_wc;
  logic [25:0]           r_data;
  logic [CW-1:0]         r_noise;
  logic [CW-1:0]         r_cw;
  logic [4:0]            r_syn;
  logic                  r_par;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_done;
  logic [1:0]            r_err;

  logic [CW-1:0] w_placed;
  logic [CW-1:0] w_enc_cw;
  logic [CW-1:0] w_pg_in;
  logic [CW-1:0] w_fixed;
  logic [25:0]   w_info;
  logic [4:0]    w_syn;
  logic          w_par;
  logic [1:0]    w_err;
  logic          w_unused_hi;

  assign w_unused_hi = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};

  always_comb begin
    w_placed = '0;
    for (int k = 0; k < 26; k++) begin
      if (k < k_of(r_wc)) w_placed[info_pos(k)] = r_data[k];
    end
  end

  // Parity positions are zero in w_placed, so its syndrome is exactly the parity vector.
  assign w_pg_in = (r_state == S_DEC) ? r_cw : w_placed;

  ecc_parity_gen u_parity_gen (
    .i_word (w_pg_in),
    .i_wc   (r_wc),
    .o_syn  (w_syn),
    .o_par  (w_par)
  );

  always_comb begin
    w_enc_cw     = w_placed;
    w_enc_cw[1]  = w_syn[0];
    w_enc_cw[2]  = w_syn[1];
    w_enc_cw[4]  = w_syn[2];
    w_enc_cw[8]  = w_syn[3];
    w_enc_cw[16] = w_syn[4];
    w_enc_cw[0]  = w_par ^ (^w_syn);
  end

  always_comb begin
    w_fixed = r_cw;
    if (r_par) w_fixed[r_syn] = ~r_cw[r_syn];
    w_info = '0;
    for (int k = 0; k < 26; k++) begin
      if (k < k_of(r_wc)) w_info[k] = w_fixed[info_pos(k)];
    end
    if (r_par)              w_err = 2'b01;
    else if (r_syn != 5'd0) w_err = 2'b10;
    else                    w_err = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_wc    <= '0;
      r_data  <= '0;
      r_noise <= '0;
      r_cw    <= '0;
      r_syn   <= '0;
      r_par   <= 1'b0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= CTRL[1:0];
            r_wc    <= CODEWORD_WIDTH[1:0];
            r_data  <= DATA_IN[25:0];
            r_noise <= CW'(NOISE);
            r_cw    <= CW'(DATA_IN) & n_mask(CODEWORD_WIDTH[1:0]);
            if (CTRL[1:0] == 2'd3 || CODEWORD_WIDTH[1:0] == 2'd3) begin
              r_state <= S_DONE;
              r_dout  <= '0;
              r_err   <= 2'b11;
              r_done  <= 1'b1;
            end else if (CTRL[1:0] == OP_DECODE) begin
              r_state <= S_DEC;
            end else begin
              r_state <= S_ENC;
            end
          end
        end
        S_ENC: begin
          r_cw <= w_enc_cw;
          if (r_op == OP_FULL_CHANNEL) begin
            r_state <= S_NOISE;
          end else begin
            r_state <= S_DONE;
            r_dout  <= DATA_WIDTH'(w_enc_cw);
            r_err   <= 2'b00;
            r_done  <= 1'b1;
          end
        end
        S_NOISE: begin
          r_cw    <= r_cw ^ (r_noise & n_mask(r_wc));
          r_state <= S_DEC;
        end
        S_DEC: begin
          r_syn   <= w_syn;
          r_par   <= w_par;
          r_state <= S_CORR;
        end
        S_CORR: begin
          r_dout  <= DATA_WIDTH'(w_info);
          r_err   <= w_err;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out       = r_dout;
  assign operation_done = r_done;
  assign num_of_errors  = r_err;

endmodule

// File: tb/tb_ecc_engine.sv
// Directed plus randomized bench for ecc_engine against an arithmetic SEC-DED model.
module tb_ecc_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] CTRL, DATA_IN, CODEWORD_WIDTH, NOISE;
  logic [31:0] data_out;
  logic        operation_done;
  logic [1:0]  num_of_errors;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ecc_engine #(.AMBA_WORD(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .CTRL           (CTRL),
    .DATA_IN        (DATA_IN),
    .CODEWORD_WIDTH (CODEWORD_WIDTH),
    .NOISE          (NOISE),
    .data_out       (data_out),
    .operation_done (operation_done),
    .num_of_errors  (num_of_errors)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nval(input int wc);
    return (wc == 0) ? 8 : (wc == 1) ? 16 : 32;
  endfunction

  function automatic logic [31:0] nmask(input int n);
    logic [31:0] one = 32'd1;
    return (n == 32) ? 32'hFFFF_FFFF : ((one << n) - 32'd1);
  endfunction

  // Info bits go to non-power-of-two positions in ascending order; each parity bit
  // covers the positions whose index has its bit set; bit 0 makes total parity even.
  function automatic logic [31:0] m_encode(input logic [31:0] d, input int n);
    logic [31:0] cw = '0;
    int k = 0;
    for (int p = 1; p < n; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k++;
      end
    end
    for (int j = 0; (1 << j) < n; j++) begin
      logic b = 1'b0;
      for (int p = 1; p < n; p++)
        if ((p & (1 << j)) != 0 && p != (1 << j)) b = b ^ cw[p];
      cw[1 << j] = b;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [33:0] m_decode(input logic [31:0] cw_in, input int n);
    logic [31:0] cw = cw_in;
    logic [31:0] d  = '0;
    logic [1:0]  e;
    int syn = 0;
    int pall = 0;
    int k = 0;
    for (int p = 0; p < n; p++) begin
      if (cw[p]) begin
        syn  = syn ^ p;
        pall = pall ^ 1;
      end
    end
    if (pall != 0) begin
      e = 2'b01;
      cw[syn] = ~cw[syn];
    end else if (syn != 0) e = 2'b10;
    else e = 2'b00;
    for (int p = 1; p < n; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = cw[p];
        k++;
      end
    end
    return {e, d};
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] wc,
                        input logic [31:0] din, input logic [31:0] nz, input int exp_lat,
                        input logic [31:0] exp_d, input logic [1:0] exp_e);
    int lat;
    @(negedge clk);
    CTRL           = {30'($urandom), op};
    CODEWORD_WIDTH = {30'($urandom), wc};
    DATA_IN        = din;
    NOISE          = nz;
    start          = 1'b1;
    @(negedge clk);
    start          = 1'b0;
    CTRL           = $urandom;
    CODEWORD_WIDTH = $urandom;
    DATA_IN        = $urandom;
    NOISE          = $urandom;
    lat = 1;
    while (operation_done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":data_out"}, data_out, exp_d);
    chk({tag, ":errors"}, 32'(num_of_errors), 32'(exp_e));
    @(negedge clk);
    chk({tag, ":pulse_width"}, 32'(operation_done), 32'd0);
  endtask

  initial begin
    int          ndone, at, n, kind, b1, b2;
    logic [31:0] dv, d, nz, cw, m;
    logic [33:0] r;
    logic [1:0]  op, wc;

    rst = 1'b1; start = 1'b0;
    CTRL = '0; DATA_IN = '0; CODEWORD_WIDTH = '0; NOISE = '0;
    repeat (3) @(negedge clk);
    chk("reset:data_out", data_out, 32'd0);
    chk("reset:done", 32'(operation_done), 32'd0);
    chk("reset:errors", 32'(num_of_errors), 32'd0);
    rst = 1'b0;

    run_op("enc8_B",     2'd0, 2'd0, 32'h0000_000B, 32'h0,  2, 32'h0000_00AA, 2'b00);
    run_op("dec8_8A",    2'd1, 2'd0, 32'h0000_008A, 32'h0,  3, 32'h0000_000B, 2'b01);
    run_op("dec8_AC",    2'd1, 2'd0, 32'h0000_00AC, 32'h0,  3, 32'h0000_000B, 2'b10);
    run_op("full8_n1",   2'd2, 2'd0, 32'h0000_000B, 32'h1,  5, 32'h0000_000B, 2'b01);
    run_op("full8_n0",   2'd2, 2'd0, 32'h0000_000B, 32'h0,  5, 32'h0000_000B, 2'b00);
    run_op("bad_ctrl",   2'd3, 2'd0, 32'h0000_000B, 32'h0,  1, 32'h0,         2'b11);
    run_op("bad_width",  2'd0, 2'd3, 32'h0000_000B, 32'h0,  1, 32'h0,         2'b11);
    run_op("dec16_clean",2'd1, 2'd1, m_encode(32'h5A5, 16), 32'h0, 3, 32'h5A5, 2'b00);

    // start pulsed again while a decode is running must be ignored
    @(negedge clk);
    CTRL = 32'd1; CODEWORD_WIDTH = 32'd0; DATA_IN = 32'h8A; start = 1'b1;
    @(negedge clk);
    CTRL = 32'd0; DATA_IN = 32'h0; start = 1'b1;
    ndone = 0; at = 0; dv = '0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) start = 1'b0;
      if (operation_done === 1'b1) begin
        ndone++;
        at = c;
        dv = data_out;
      end
      @(negedge clk);
    end
    chk("restart:done_count", 32'(ndone), 32'd1);
    chk("restart:done_cycle", 32'(at), 32'd3);
    chk("restart:data_out", dv, 32'h0000_000B);

    // reset in cycle T+3 of a full-channel run aborts it
    @(negedge clk);
    CTRL = 32'd2; CODEWORD_WIDTH = 32'd0; DATA_IN = 32'hB; NOISE = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      if (operation_done === 1'b1) ndone++;
      if (c == 3) rst = 1'b1;
      if (c == 4) rst = 1'b0;
      @(negedge clk);
    end
    chk("abort:done_count", 32'(ndone), 32'd0);
    chk("abort:data_out", data_out, 32'd0);
    chk("abort:errors", 32'(num_of_errors), 32'd0);
    run_op("enc32_zero", 2'd0, 2'd2, 32'h0, 32'h0, 2, 32'h0, 2'b00);
    run_op("enc32_ones", 2'd0, 2'd2, 32'h03FF_FFFF, 32'h0, 2, m_encode(32'h03FF_FFFF, 32), 2'b00);

    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 2));
      wc   = 2'($urandom_range(0, 2));
      n    = nval(int'(wc));
      m    = nmask(n);
      d    = $urandom;
      kind = $urandom_range(0, 2);
      b1   = $urandom_range(0, n - 1);
      b2   = (b1 + $urandom_range(1, n - 1)) % n;
      nz   = '0;
      if (kind >= 1) nz[b1] = 1'b1;
      if (kind == 2) nz[b2] = 1'b1;
      if (op == 2'd0) begin
        run_op($sformatf("rnd%0d_enc", i), op, wc, d, $urandom, 2, m_encode(d, n), 2'b00);
      end else if (op == 2'd1) begin
        cw = m_encode(d, n) ^ nz;
        r  = m_decode(cw, n);
        run_op($sformatf("rnd%0d_dec", i), op, wc, cw | (~m & $urandom), $urandom, 3, r[31:0], r[33:32]);
      end else begin
        r = m_decode(m_encode(d, n) ^ nz, n);
        run_op($sformatf("rnd%0d_full", i), op, wc, d, nz | (~m & $urandom), 5, r[31:0], r[33:32]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecc_engine.md
# ecc_engine

Sequential Hamming SEC-DED encode/decode engine that sits directly downstream of the APB register slave. It consumes the `start`, `CTRL`, `DATA_IN`, `CODEWORD_WIDTH` and `NOISE` register outputs. It performs encode, decode, or full-channel (encode → inject noise → decode) for 8/16/32-bit codewords, then reports the result with a one-cycle `operation_done` pulse.

## Interface
- AMBA_WORD, 32, width of all register inputs
- DATA_WIDTH, 32, width of `data_out`
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle launch pulse from the register slave
- CTRL  in  AMBA_WORD  operation; bits [1:0]: 0 encode, 1 decode, 2 full channel, 3 reserved
- DATA_IN  in  AMBA_WORD  info word (encode/full) or received codeword (decode)
- CODEWORD_WIDTH  in  AMBA_WORD  bits [1:0]: 0 → N=8 (K=4), 1 → N=16 (K=11), 2 → N=32 (K=26), 3 reserved
- NOISE  in  AMBA_WORD  error mask XORed onto codeword bits [N-1:0] in full-channel mode
- data_out  out  DATA_WIDTH  codeword (encode) or corrected info word (decode/full), zero-extended
- operation_done  out  1  one-cycle pulse; `data_out` and `num_of_errors` are valid from this cycle
- num_of_errors  out  2  00 none, 01 single (corrected), 10 double (uncorrectable), 11 invalid command

## Operation
- **Codeword layout**
  - Bit i (1..N-1) is Hamming position i.
  - Parity bits sit at positions 1, 2, 4, 8, 16 (only those < N).
  - Info bits fill the remaining positions in ascending order, `DATA_IN[0]` first.
  - Bit 0 is the overall even-parity bit over bits 1..N-1.
  - Bits ≥ N of `data_out` are 0.
- **Encode:** parity p_j = XOR of all bits in positions with index bit j set; then compute bit 0.
- **Decode:**
  - syndrome = XOR of the indices of set bits in 1..N-1.
  - P = XOR of bits 0..N-1.
  - syndrome=0, P=0 → 00, no correction.
  - P=1 → 01; flip the bit at position syndrome (syndrome 0 means bit 0).
  - syndrome≠0, P=0 → 10; extract the info bits uncorrected.
- **Full channel:** the encoded word is XORed with `NOISE[N-1:0]`, then decoded as above.
- **Operand capture:** `CTRL[1:0]`, `CODEWORD_WIDTH[1:0]`, `DATA_IN`, `NOISE` are captured into internal registers on the launch edge. Later input changes have no effect until the next launch.
- **FSM states:** IDLE, ENC, NOISE, DEC, CORR, DONE.
  - IDLE + start: valid encode → ENC; decode → DEC; full → ENC.
  - ENC → DONE (encode) or NOISE (full).
  - NOISE → DEC; DEC → CORR; CORR → DONE; DONE → IDLE.
  - Reserved CTRL or CODEWORD_WIDTH → DONE directly, with `data_out`=0 and `num_of_errors`=11.
- `start` outside IDLE is ignored: no queueing, no restart.
- Outputs are registered and hold their last result until the next DONE.

## Timing
- Reset (rst=1 at a clk edge): state IDLE, `data_out`=0, `operation_done`=0, `num_of_errors`=00, operand registers 0.
- Reset mid-operation aborts the operation: no done pulse; state returns to IDLE in the next cycle.
- With start high in cycle T (launch edge at end of T), `operation_done` is high in:
  - encode: T+2
  - decode: T+3
  - full channel: T+5
  - invalid command: T+1
- `operation_done` is high for exactly one cycle. `data_out` and `num_of_errors` update on the same edge that raises it.
- Earliest accepted relaunch is the cycle after DONE; back-to-back operations are therefore separated by one IDLE cycle.
- start and rst in the same cycle: reset wins.

## Structure
- Package `ecc_pkg` holds:
  - the state enum;
  - op-code constants (ENCODE, DECODE, FULL_CHANNEL);
  - width-code constants and the N/K lookup functions;
  - a function mapping info-bit index to Hamming position per N.
- Sub-module `ecc_parity_gen` (combinational) computes the 5-bit syndrome/parity vector and overall parity for a 32-bit word masked to N.
  - It is shared by ENC (parity generation with parity positions zeroed) and DEC (syndrome).
- Top `ecc_engine` holds the FSM, operand/codeword registers, noise XOR, correction and extraction.

## Test plan
- Encode, N=8, `DATA_IN`=0xB → done at T+2; `data_out`=0xAA, errors 00.
- Decode, N=8, `DATA_IN`=0x8A (bit 5 flipped) → done at T+3; `data_out`=0xB, errors 01.
- Decode, N=8, `DATA_IN`=0xAC (bits 1, 2 flipped) → errors 10, no correction applied.
- Full channel, N=8:
  - `DATA_IN`=0xB, `NOISE`=0x01 → done at T+5; `data_out`=0xB, errors 01.
  - `NOISE`=0 → errors 00.
- Error handling:
  - `CTRL`=3 → done at T+1, `data_out`=0, errors 11.
  - start pulsed again during a running decode → ignored; exactly one done pulse.
- Reset mid full-channel run (rst in T+3) → no done pulse, outputs 0. A fresh N=32 encode of `DATA_IN`=0 then gives `data_out`=0.
